// File: rtl/soc_rst_pkg.sv
// Shared types and PIO bit positions for the ao486 reset sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package soc_rst_pkg;

  // Sequencer states; the encoding is visible to firmware on pio_input[5:4]
  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    PULSE = 2'd2
  } state_t;

  // pio_output bit positions (firmware -> sequencer)
  localparam int RUN_REQ   = 0;
  localparam int SOFT_RST  = 1;
  localparam int HEARTBEAT = 7;

  // pio_input bit positions (sequencer -> firmware)
  localparam int WDT_FLAG  = 6;
  localparam int RUNNING   = 7;

endpackage

// File: rtl/soc_key_debounce.sv
// Synchronises one active-low board key and accepts a new level once it has been stable.
// Latency: a level change is reported 2 + DEB_CYCLES clk cycles after it appears on key_n.
// Backpressure: none; pressed is a continuous level output.
module soc_key_debounce #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pressed
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Two-flop synchroniser; resets to the released (high) level so no change is seen at start-up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // Stability counter: restarts whenever the synchronised level matches the accepted one again
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b1;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= sync2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign pressed = ~level;

endmodule

// File: rtl/soc_reset_sequencer.sv
// Holds/pulses the ao486 CPU reset under Nios firmware control and reports debounced keys.
// Latency: ao486_reset asserts 1 cycle after a synchronised trigger edge; pulses last >= RST_CYCLES.
// Backpressure: none; trigger requests arriving during a pulse are dropped. Watchdog: SOC_RST_WDT_EN.
module soc_reset_sequencer
  import soc_rst_pkg::*;
#(
  parameter int DEB_CYCLES = 250000,
  parameter int RST_CYCLES = 1024,
  parameter int WDT_CYCLES = 2**26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_n,
  input  logic [7:0] pio_output,
  output logic [7:0] pio_input,
  output logic       ao486_reset
);

  localparam int PW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [PW-1:0] PULSE_LAST = PW'(RST_CYCLES - 1);

  logic [3:0]    key_pressed;
  logic          key0_prev;
  logic          key0_rise;
  logic [7:0]    po_sync1;
  logic [7:0]    po_sync2;
  logic          soft_prev;
  logic          soft_rise;
  logic          run_req;
  logic          trigger;
  logic          wdt_fire;
  logic          wdt_flag;
  logic          running;
  logic          unused_pio;
  logic [PW-1:0] pulse_cnt;
  state_t        state;

  for (genvar k = 0; k < 4; k++) begin : g_key
    soc_key_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk     (clk),
      .rst_n   (rst_n),
      .key_n   (key_n[k]),
      .pressed (key_pressed[k])
    );
  end

  // Firmware controls cross from the Nios PIO domain through a two-flop synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      po_sync1 <= '0;
      po_sync2 <= '0;
    end else begin
      po_sync1 <= pio_output;
      po_sync2 <= po_sync1;
    end
  end

  // Previous values for edge detection on soft reset and on the key0 press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      soft_prev <= 1'b0;
      key0_prev <= 1'b0;
    end else begin
      soft_prev <= po_sync2[SOFT_RST];
      key0_prev <= key_pressed[0];
    end
  end

  assign run_req   = po_sync2[RUN_REQ];
  assign soft_rise = po_sync2[SOFT_RST] & ~soft_prev;
  assign key0_rise = key_pressed[0] & ~key0_prev;
  // Coincident sources collapse into a single pulse request
  assign trigger   = soft_rise | key0_rise | wdt_fire;

`ifdef SOC_RST_WDT_EN
  localparam int WW = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);

  logic [WW-1:0] wdt_cnt;
  logic          hb_prev;
  logic          hb_toggle;

  assign hb_toggle  = po_sync2[HEARTBEAT] ^ hb_prev;
  assign wdt_fire   = (state == RUN) && (wdt_cnt == WDT_LAST);
  assign unused_pio = ^po_sync2[6:2];

  // Heartbeat timeout: counts only in RUN, restarted by either heartbeat edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_cnt <= '0;
      hb_prev <= 1'b0;
    end else begin
      hb_prev <= po_sync2[HEARTBEAT];
      if (state != RUN || hb_toggle) begin
        wdt_cnt <= '0;
      end else if (!wdt_fire) begin
        wdt_cnt <= wdt_cnt + 1'b1;
      end
    end
  end

  // Sticky firmware flag; only a run_req drop (or rst_n) acknowledges it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_flag <= 1'b0;
    end else if (!run_req) begin
      wdt_flag <= 1'b0;
    end else if (wdt_fire) begin
      wdt_flag <= 1'b1;
    end
  end
`else
  assign wdt_fire   = 1'b0;
  assign wdt_flag   = 1'b0;
  assign unused_pio = ^po_sync2[7:2];
`endif

  // Sequencer FSM with the pulse-width counter and registered reset/running outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HOLD;
      pulse_cnt   <= '0;
      ao486_reset <= 1'b1;
      running     <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          ao486_reset <= 1'b1;
          running     <= 1'b0;
          if (pulse_cnt == PULSE_LAST) begin
            if (run_req) begin
              state       <= RUN;
              ao486_reset <= 1'b0;
              running     <= 1'b1;
            end
          end else begin
            pulse_cnt <= pulse_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!run_req) begin
            state       <= HOLD;
            pulse_cnt   <= '0;
            ao486_reset <= 1'b1;
            running     <= 1'b0;
          end else if (trigger) begin
            state       <= PULSE;
            pulse_cnt   <= '0;
            ao486_reset <= 1'b1;
            running     <= 1'b0;
          end else begin
            ao486_reset <= 1'b0;
            running     <= 1'b1;
          end
        end
        PULSE: begin
          // New requests are ignored here; the width counter is never restarted
          if (pulse_cnt == PULSE_LAST) begin
            if (run_req) begin
              state       <= RUN;
              ao486_reset <= 1'b0;
              running     <= 1'b1;
            end else begin
              state       <= HOLD;
              pulse_cnt   <= '0;
              ao486_reset <= 1'b1;
              running     <= 1'b0;
            end
          end else begin
            pulse_cnt   <= pulse_cnt + 1'b1;
            ao486_reset <= 1'b1;
          end
        end
        default: begin
          state       <= HOLD;
          pulse_cnt   <= '0;
          ao486_reset <= 1'b1;
          running     <= 1'b0;
        end
      endcase
    end
  end

  // Firmware status word assembled from registered state only
  always_comb begin
    pio_input           = 8'h00;
    pio_input[3:0]      = key_pressed;
    pio_input[5:4]      = state;
    pio_input[WDT_FLAG] = wdt_flag;
    pio_input[RUNNING]  = running;
  end

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// Directed bench for soc_reset_sequencer with DEB_CYCLES=8, RST_CYCLES=16, WDT_CYCLES=64.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
// Watchdog scenario is selected by SOC_RST_WDT_EN, matching the RTL build.
module tb_soc_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] key_n = 4'hF;
  logic [7:0] pio_output = 8'h00;
  logic [7:0] pio_input;
  logic       ao486_reset;

  int checks = 0;
  int errors = 0;

  soc_reset_sequencer #(
    .DEB_CYCLES(8),
    .RST_CYCLES(16),
    .WDT_CYCLES(64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_n       (key_n),
    .pio_output  (pio_output),
    .pio_input   (pio_input),
    .ao486_reset (ao486_reset)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
    int n = 0;
    while (pio_input[5:4] != s && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, {30'd0, pio_input[5:4]}, {30'd0, s});
  endtask

  initial begin
    int highs;
    int rises;
    int lows;
    logic prev;
    logic bounce_hi;
    logic key_seen;

    // Power-on reset
    #3 rst_n = 1'b0;
    tick(2);
    check("rst_ao486", {31'd0, ao486_reset}, 32'd1);
    check("rst_pio", {24'd0, pio_input}, 32'h00);
    rst_n = 1'b1;

    // HOLD persists while run_req stays low
    tick(100);
    check("hold_ao486", {31'd0, ao486_reset}, 32'd1);
    check("hold_pio", {24'd0, pio_input}, 32'h00);

    // run_req at cycle 3: release only after the 16-cycle minimum
    do_reset();
    tick(3);
    pio_output[0] = 1'b1;
    tick(12);
    check("run_min_width", {31'd0, ao486_reset}, 32'd1);
    tick(1);
    check("run_release", {31'd0, ao486_reset}, 32'd0);
    check("run_pio", {24'd0, pio_input}, 32'h90);

    // One-cycle soft reset strobe -> exactly 16 cycles of reset
    pio_output[1] = 1'b1;
    tick(1);
    pio_output[1] = 1'b0;
    tick(1);
    check("soft_not_yet", {31'd0, ao486_reset}, 32'd0);
    tick(1);
    check("soft_assert", {31'd0, ao486_reset}, 32'd1);
    check("soft_pio", {24'd0, pio_input}, 32'h20);
    highs = 1;
    repeat (30) begin
      tick(1);
      if (ao486_reset) highs++;
    end
    check("soft_width", highs, 16);
    check("soft_back_run", {24'd0, pio_input}, 32'h90);

    // Second strobe during a pulse is ignored and does not stretch it
    highs = 0;
    for (int i = 0; i < 45; i++) begin
      if (i == 0 || i == 7) pio_output[1] = 1'b1;
      if (i == 1 || i == 8) pio_output[1] = 1'b0;
      tick(1);
      if (ao486_reset) highs++;
    end
    check("retrig_width", highs, 16);
    check("retrig_pio", {24'd0, pio_input}, 32'h90);

    // Key0 bouncing every 3 cycles, then held pressed
    bounce_hi = 1'b0;
    key_seen  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      key_n[0] = ~key_n[0];
      repeat (3) begin
        tick(1);
        bounce_hi |= ao486_reset;
        key_seen  |= pio_input[0];
      end
    end
    key_n[0] = 1'b0;
    repeat (9) begin
      tick(1);
      bounce_hi |= ao486_reset;
      key_seen  |= pio_input[0];
    end
    check("bounce_no_key", {31'd0, key_seen}, 32'd0);
    check("bounce_no_rst", {31'd0, bounce_hi}, 32'd0);
    tick(1);
    check("key_report", {24'd0, pio_input}, 32'h91);
    check("key_pre_pulse", {31'd0, ao486_reset}, 32'd0);
    tick(1);
    check("key_pulse", {31'd0, ao486_reset}, 32'd1);
    highs = 1;
    rises = 0;
    prev  = ao486_reset;
    repeat (40) begin
      tick(1);
      if (ao486_reset) highs++;
      if (ao486_reset && !prev) rises++;
      prev = ao486_reset;
    end
    check("key_width", highs, 16);
    check("key_single", rises, 0);

    // Key release is not a trigger
    key_n[0] = 1'b1;
    tick(12);
    check("release_pio", {24'd0, pio_input}, 32'h90);
    check("release_ao486", {31'd0, ao486_reset}, 32'd0);

    // run_req drop in RUN -> HOLD on the third edge
    pio_output[0] = 1'b0;
    tick(2);
    check("drop_not_yet", {31'd0, ao486_reset}, 32'd0);
    tick(1);
    check("drop_ao486", {31'd0, ao486_reset}, 32'd1);
    check("drop_pio", {24'd0, pio_input}, 32'h00);

    // rst_n asserted at cycle 5 of a pulse takes effect without a clock
    pio_output[0] = 1'b1;
    wait_state(2'd1, 60, "rerun_state");
    pio_output[1] = 1'b1;
    tick(1);
    pio_output[1] = 1'b0;
    tick(2);
    check("mid_pulse_state", {30'd0, pio_input[5:4]}, 32'd2);
    tick(4);
    #2 rst_n = 1'b0;
    #1;
    check("async_ao486", {31'd0, ao486_reset}, 32'd1);
    check("async_pio", {24'd0, pio_input}, 32'h00);
    tick(2);
    rst_n = 1'b1;

    // run_req dropped during a pulse -> exit to HOLD, reset never released
    wait_state(2'd1, 60, "rerun2_state");
    pio_output[1] = 1'b1;
    tick(1);
    pio_output[1] = 1'b0;
    tick(2);
    pio_output[0] = 1'b0;
    lows = 0;
    repeat (25) begin
      tick(1);
      if (!ao486_reset) lows++;
    end
    check("pulse_drop_lows", lows, 0);
    check("pulse_drop_pio", {24'd0, pio_input}, 32'h00);

`ifdef SOC_RST_WDT_EN
    // Silent heartbeat -> watchdog pulse after 64 RUN cycles, sticky flag
    pio_output[0] = 1'b1;
    wait_state(2'd1, 60, "wdt_run_state");
    begin
      int run_cycles = 1;
      int n = 0;
      while (pio_input[5:4] == 2'd1 && n < 200) begin
        tick(1);
        n++;
        if (pio_input[5:4] == 2'd1) run_cycles++;
      end
      check("wdt_run_cycles", run_cycles, 64);
    end
    check("wdt_pulse_state", {30'd0, pio_input[5:4]}, 32'd2);
    check("wdt_flag_set", {31'd0, pio_input[6]}, 32'd1);
    wait_state(2'd1, 60, "wdt_rerun_state");
    check("wdt_flag_sticky", {31'd0, pio_input[6]}, 32'd1);
    pio_output[0] = 1'b0;
    tick(4);
    check("wdt_flag_clear", {31'd0, pio_input[6]}, 32'd0);
    check("wdt_hold_state", {30'd0, pio_input[5:4]}, 32'd0);
`else
    // Without the watchdog a silent heartbeat never disturbs RUN
    pio_output[0] = 1'b1;
    wait_state(2'd1, 60, "nowdt_run_state");
    lows = 0;
    repeat (100) begin
      tick(1);
      if (ao486_reset) lows++;
    end
    check("nowdt_no_pulse", lows, 0);
    check("nowdt_pio", {24'd0, pio_input}, 32'h90);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
